ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter for the single-port block RAM (one access per cycle, 1-cycle registered read latency).
- Port 0 is the CPU data/instruction port; port 1 is the host/loader port (program load, memory dump, debug peek/poke).
- Grants one requester per cycle, drives the RAM address, write-enable and write data combinationally, and routes read data back with a valid strobe one cycle later.
- Supports a lock so one requester can hold the RAM for read-modify-write sequences.

Parameters:
- ADDR_W, 14, address width of both requesters and the RAM
- DATA_W, 32, data word width
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins when both request

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req0  input  1  port 0 access request
- we0  input  1  port 0 write (1) / read (0)
- lock0  input  1  port 0 requests to keep ownership after this access
- addr0  input  ADDR_W  port 0 address
- wdata0  input  DATA_W  port 0 write data
- gnt0  output  1  port 0 access performed this cycle
- rvalid0  output  1  port 0 read data valid (cycle after read grant)
- rdata0  output  DATA_W  port 0 read data
- req1, we1, lock1, addr1, wdata1  input  (same widths)  port 1 equivalents
- gnt1, rvalid1, rdata1  output  (same widths)  port 1 equivalents
- ram_we  output  1  RAM write enable
- ram_addr  output  ADDR_W  RAM address
- ram_wdata  output  DATA_W  RAM write data
- ram_rdata  input  DATA_W  RAM registered read data

Behaviour:
- Registers:
  - last (last-granted port, reset 1, so port 0 wins the first tie)
  - owner_valid / owner (lock ownership, reset 0)
  - rd_pend0 / rd_pend1 (reset 0)
- Reset values:
  - rvalid0 = rvalid1 = 0 from the cycle after rst is sampled high.
  - gnt0, gnt1 and ram_we are forced to 0 while rst = 1.
  - ram_addr and ram_wdata are 0 when idle.
- Arbitration (combinational, each cycle):
  - If owner_valid: only the owner may be granted; the other port waits even if requesting.
  - Otherwise, with exactly one req: grant it.
  - With both req: FIXED_PRIO = 1 → port 0; FIXED_PRIO = 0 → the port ≠ last.
- Grant effects (same cycle): ram_addr = addrN, ram_we = weN, ram_wdata = wdataN when writing, else 0.
- A requester holds req, we, addr and wdata stable until it sees gnt; gnt is a one-cycle accept, so hold req for back-to-back accesses.
- On a grant: last <= N.
- Lock:
  - If lockN = 1 with the grant: owner_valid <= 1, owner <= N.
  - Owner grant with lockN = 0: owner_valid <= 0 after that access.
  - An owner that drops req while locked keeps ownership; the other port stays blocked.
- Read return:
  - Read grant at cycle T: rd_pendN <= 1, and rvalidN = 1 at T+1 with rdataN = ram_rdata (pass-through).
  - rdataN is 0 when rvalidN = 0.
  - Writes never raise rvalid.
- Latency / throughput:
  - Grant in the request cycle when uncontended; read data at +1.
  - One access per cycle total, back-to-back allowed, including alternating ports every cycle under round-robin.
- RAM semantics passed through unchanged:
  - A write at T followed by a read of the same address at T+1 returns the new data at T+2.
  - A read never coincides with a write (single port).
- Reset mid-operation: a pending read is dropped (no rvalid), the lock is cleared, last <= 1.
- No requests: gnt0 = gnt1 = 0, ram_we = 0, state unchanged (lock persists).

Test Plan:
- Single port 0, write addr 0x45 data 0x1 at T, read 0x45 at T+1 → gnt0 both cycles; rvalid0 = 1 and rdata0 = 0x1 at T+2; gnt1 never asserted.
- Both ports request reads (port 0 addr 0x64 = 6, port 1 addr 0x46 = 0x3E8) from reset, FIXED_PRIO = 0 → gnt0 then gnt1; rvalid0 with 6, then rvalid1 with 0x3E8; rvalids never overlap.
- Both request continuously for 8 cycles, round-robin → grants alternate 0,1,0,1…, exactly 4 each; FIXED_PRIO = 1 → 8 grants to port 0, port 1 starved until req0 drops.
- Port 1 reads 0x48 with lock1 = 1, then port 0 requests continuously while port 1 writes 0x48 = 3 with lock1 = 0 → port 0 blocked for both cycles, granted on the following cycle; the RAM value is 3.
- Port 0 read granted at T, rst = 1 at T+1 → rvalid0 stays 0; lock cleared; after reset, a tie grants port 0 first.
- Idle cycles with owner_valid = 1 (lock1 held, req1 = 0) → req0 never granted until port 1 completes an access with lock1 = 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter with lock for a single-port registered-read block RAM
module ram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  logic last, owner_valid, owner, rd_pend0, rd_pend1, pick1;
  // pick a winner (lock owner, sole requester, or priority/round-robin tie-break) and steer the RAM
  always_comb begin
    pick1 = owner_valid ? owner : req1 & (~req0 | ((FIXED_PRIO == 0) & ~last));
    gnt0 = ~rst & req0 & ~pick1;
    gnt1 = ~rst & req1 & pick1;
    ram_addr = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    ram_we = gnt0 ? we0 : gnt1 & we1;
    ram_wdata = ram_we ? (gnt0 ? wdata0 : wdata1) : '0;
    rvalid0 = rd_pend0 & ~rst;
    rvalid1 = rd_pend1 & ~rst;
    rdata0 = rvalid0 ? ram_rdata : '0;
    rdata1 = rvalid1 ? ram_rdata : '0;
  end
  // track last winner, lock ownership and outstanding reads
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
      owner_valid <= 1'b0;
      owner <= 1'b0;
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
    end else begin
      rd_pend0 <= gnt0 & ~we0;
      rd_pend1 <= gnt1 & ~we1;
      if (gnt0 | gnt1) begin
        last <= gnt1;
        owner <= gnt1;
        owner_valid <= gnt1 ? lock1 : lock0;
      end
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of arbitration, lock, read return and reset
module tb_ram_arbiter;
  logic clk = 0, rst = 1;
  logic req0 = 0, we0 = 0, lock0 = 0, req1 = 0, we1 = 0, lock1 = 0;
  logic [13:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic gnt0, rvalid0, gnt1, rvalid1, ram_we;
  logic [31:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [13:0] ram_addr;
  logic f_gnt0, f_rvalid0, f_gnt1, f_rvalid1, f_ram_we;
  logic [31:0] f_rdata0, f_rdata1, f_ram_wdata, f_ram_rdata;
  logic [13:0] f_ram_addr;
  logic [31:0] mem_a [0:16383];
  logic [31:0] mem_f [0:16383];
  int total = 0, bad = 0;
  int n0, n1, f0, f1;

  always #5 clk = ~clk;

  ram_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(f_gnt0), .rvalid0(f_rvalid0), .rdata0(f_rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(f_gnt1), .rvalid1(f_rvalid1), .rdata1(f_rdata1),
    .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_rdata(f_ram_rdata)
  );

  // registered-read single-port RAM models
  always @(posedge clk) begin
    if (ram_we) mem_a[ram_addr] <= ram_wdata;
    ram_rdata <= mem_a[ram_addr];
    if (f_ram_we) mem_f[f_ram_addr] <= f_ram_wdata;
    f_ram_rdata <= mem_f[f_ram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem_a[i] = 0;
      mem_f[i] = 0;
    end
    mem_a[14'h64] = 6; mem_a[14'h46] = 32'h3E8; mem_a[14'h48] = 7;
    req0 = 1; we0 = 1;
    cyc; cyc;
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0); chk("rst_we", ram_we, 0); chk("rst_rv0", rvalid0, 0); chk("rst_rv1", rvalid1, 0);
    cyc;
    rst = 0; req0 = 1; we0 = 1; addr0 = 14'h45; wdata0 = 1;
    @(negedge clk);
    chk("wr_gnt0", gnt0, 1); chk("wr_gnt1", gnt1, 0); chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 14'h45); chk("wr_data", ram_wdata, 1);
    cyc;
    we0 = 0;
    @(negedge clk);
    chk("rd_gnt0", gnt0, 1); chk("rd_we", ram_we, 0); chk("rd_wdata", ram_wdata, 0); chk("wr_no_rv", rvalid0, 0);
    cyc;
    req0 = 0;
    @(negedge clk);
    chk("rar_rv0", rvalid0, 1); chk("rar_data", rdata0, 1); chk("rar_gnt1", gnt1, 0);
    chk("idle_addr", ram_addr, 0);
    cyc;
    rst = 1;
    cyc;
    rst = 0; req0 = 1; we0 = 0; addr0 = 14'h64; req1 = 1; we1 = 0; addr1 = 14'h46;
    @(negedge clk);
    chk("tie_gnt0", gnt0, 1); chk("tie_gnt1", gnt1, 0); chk("tie_addr", ram_addr, 14'h64);
    cyc;
    req0 = 0;
    @(negedge clk);
    chk("b_gnt1", gnt1, 1); chk("b_rv0", rvalid0, 1); chk("b_rd0", rdata0, 6); chk("b_rv1", rvalid1, 0);
    cyc;
    req1 = 0;
    @(negedge clk);
    chk("c_rv1", rvalid1, 1); chk("c_rd1", rdata1, 32'h3E8); chk("c_rv0", rvalid0, 0); chk("c_rd0", rdata0, 0);
    cyc;
    req0 = 1; addr0 = 1; req1 = 1; addr1 = 2;
    n0 = 0; n1 = 0; f0 = 0; f1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_alt", gnt0, 64'(i % 2 == 0));
      n0 += int'(gnt0); n1 += int'(gnt1); f0 += int'(f_gnt0); f1 += int'(f_gnt1);
      cyc;
    end
    chk("rr_n0", 64'(n0), 4); chk("rr_n1", 64'(n1), 4);
    chk("fp_n0", 64'(f0), 8); chk("fp_n1", 64'(f1), 0);
    req0 = 0;
    @(negedge clk);
    chk("fp_starve_end", f_gnt1, 1); chk("rr_solo1", gnt1, 1);
    cyc;
    addr1 = 14'h48; lock1 = 1;
    @(negedge clk);
    chk("lk_gnt1", gnt1, 1); chk("lk_addr", ram_addr, 14'h48);
    cyc;
    req1 = 0; req0 = 1; addr0 = 14'h48;
    @(negedge clk);
    chk("lk_idle_gnt0", gnt0, 0); chk("lk_idle_fp", f_gnt0, 0); chk("lk_idle_we", ram_we, 0);
    chk("lk_rv1", rvalid1, 1); chk("lk_rd1", rdata1, 7);
    cyc;
    req1 = 1; we1 = 1; wdata1 = 3; lock1 = 0;
    @(negedge clk);
    chk("ul_gnt1", gnt1, 1); chk("ul_gnt0", gnt0, 0); chk("ul_we", ram_we, 1); chk("ul_wdata", ram_wdata, 3);
    cyc;
    req1 = 0; we1 = 0;
    @(negedge clk);
    chk("ul_after_gnt0", gnt0, 1); chk("ul_after_addr", ram_addr, 14'h48);
    cyc;
    req0 = 0;
    @(negedge clk);
    chk("ul_rv0", rvalid0, 1); chk("ul_rd0", rdata0, 3); chk("ul_mem", mem_a[14'h48], 3);
    cyc;
    req0 = 1; addr0 = 14'h45; lock0 = 1;
    @(negedge clk);
    chk("pr_gnt0", gnt0, 1);
    cyc;
    rst = 1; req0 = 0; lock0 = 0;
    @(negedge clk);
    chk("pr_rv0_rst", rvalid0, 0); chk("pr_rd0_rst", rdata0, 0);
    cyc;
    rst = 0; req1 = 1; addr1 = 14'h45;
    @(negedge clk);
    chk("pr_rv0_after", rvalid0, 0); chk("pr_lock_clr", gnt1, 1);
    cyc;
    req1 = 0;
    @(negedge clk);
    chk("pr_rv1", rvalid1, 1); chk("pr_rd1", rdata1, 1);
    chk("idle_g0", gnt0, 0); chk("idle_g1", gnt1, 0); chk("idle_we", ram_we, 0); chk("idle_wd", ram_wdata, 0);
    cyc;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
